// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Control sequencer for the shared operand ROM / ALU datapath. Fetches A and B
// from two consecutive ROM words, then forms A*B by repeated addition or A/B by
// repeated subtraction, issuing one ALU operation per cycle.
// Optional feature macro: SEQ_DIV_EN
//   defined   -> divide path is built (op=1 divides, B==0 flags err)
//   undefined -> divide path is not built; op=1 finishes early with err=1
module muldiv_sequencer #(
    parameter int DW  = 16,
    parameter int OPW = 8,
    parameter int AW  = 9
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_op,
    input  logic [AW-1:0]  i_base_addr,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic [AW-1:0]  o_rom_addr,
    input  logic [OPW-1:0] i_rom_data,
    output logic [DW-1:0]  o_alu_a,
    output logic [DW-1:0]  o_alu_b,
    output logic           o_alu_op,
    input  logic [DW-1:0]  i_alu_y,
    output logic [DW-1:0]  o_result,
    output logic [DW-1:0]  o_remainder,
    output logic [DW-1:0]  o_iter_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FA   = 3'd1,
        S_FB   = 3'd2,
        S_LB   = 3'd3,
        S_EX   = 3'd4,
        S_DN   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_op;
    logic [AW-1:0]   r_base;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_acc;
    logic [DW-1:0]   r_cnt;
    logic [DW-1:0]   r_iter;
    logic            r_err;
    logic [DW-1:0]   r_result;
    logic [DW-1:0]   r_remainder;
    logic [DW-1:0]   r_iter_count;
`ifdef SEQ_DIV_EN
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_q;
`endif

    logic [AW-1:0]   w_rom_addr;
    logic [DW-1:0]   w_alu_a;
    logic [DW-1:0]   w_alu_b;
    logic            w_alu_op;
    logic            w_alu_fire;
    logic [DW-1:0]   w_rom_ext;

    // ROM words are unsigned operands, zero-extended to the ALU width
    assign w_rom_ext = {{(DW-OPW){1'b0}}, i_rom_data};

    // State register; reset aborts any operation straight back to IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus the ROM address and ALU control decoded from state
    always_comb begin
        w_state_next = r_state;
        w_rom_addr   = '0;
        w_alu_a      = '0;
        w_alu_b      = '0;
        w_alu_op     = 1'b0;
        w_alu_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_FA;
                end
            end
            S_FA: begin
                w_rom_addr   = r_base;
                w_state_next = S_FB;
            end
            S_FB: begin
                // Address arithmetic is AW bits wide, so base+1 wraps naturally
                w_rom_addr   = r_base + AW'(1);
                w_state_next = S_LB;
            end
            S_LB: begin
                if (r_op) begin
`ifdef SEQ_DIV_EN
                    w_state_next = (i_rom_data == '0) ? S_DN : S_EX;
`else
                    w_state_next = S_DN;
`endif
                end else begin
                    w_state_next = S_EX;
                end
            end
            S_EX: begin
                if (r_op) begin
`ifdef SEQ_DIV_EN
                    // Last EX cycle is a pure compare: no ALU op is issued
                    if (r_acc < r_b) begin
                        w_state_next = S_DN;
                    end else begin
                        w_alu_a    = r_acc;
                        w_alu_b    = r_b;
                        w_alu_op   = 1'b1;
                        w_alu_fire = 1'b1;
                    end
`else
                    w_state_next = S_DN;
`endif
                end else begin
                    if (r_cnt == '0) begin
                        w_state_next = S_DN;
                    end else begin
                        w_alu_a    = r_acc;
                        w_alu_b    = r_a;
                        w_alu_op   = 1'b0;
                        w_alu_fire = 1'b1;
                    end
                end
            end
            S_DN: begin
                // start in this cycle is deliberately not looked at
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, accumulation, and result load on entry to DN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op         <= 1'b0;
            r_base       <= '0;
            r_a          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_iter       <= '0;
            r_err        <= 1'b0;
            r_result     <= '0;
            r_remainder  <= '0;
            r_iter_count <= '0;
`ifdef SEQ_DIV_EN
            r_b          <= '0;
            r_q          <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op   <= i_op;
                        r_base <= i_base_addr;
                        r_err  <= 1'b0;
                    end
                end
                S_FB: begin
                    r_a <= w_rom_ext;
                end
                S_LB: begin
                    r_iter <= '0;
                    if (r_op) begin
`ifdef SEQ_DIV_EN
                        r_b   <= w_rom_ext;
                        r_acc <= r_a;
                        r_q   <= '0;
                        if (i_rom_data == '0) begin
                            r_err        <= 1'b1;
                            r_result     <= '0;
                            r_remainder  <= r_a;
                            r_iter_count <= '0;
                        end
`else
                        r_acc        <= '0;
                        r_err        <= 1'b1;
                        r_result     <= '0;
                        r_remainder  <= '0;
                        r_iter_count <= '0;
`endif
                    end else begin
                        r_acc <= '0;
                        r_cnt <= w_rom_ext;
                    end
                end
                S_EX: begin
                    if (w_alu_fire) begin
                        r_acc  <= i_alu_y;
                        r_iter <= r_iter + DW'(1);
                        if (r_op) begin
`ifdef SEQ_DIV_EN
                            r_q <= r_q + DW'(1);
`endif
                        end else begin
                            r_cnt <= r_cnt - DW'(1);
                        end
                    end else begin
                        r_iter_count <= r_iter;
                        if (r_op) begin
`ifdef SEQ_DIV_EN
                            r_result    <= r_q;
                            r_remainder <= r_acc;
`endif
                        end else begin
                            r_result    <= r_acc;
                            r_remainder <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DN);
    assign o_err        = r_err;
    assign o_rom_addr   = w_rom_addr;
    assign o_alu_a      = w_alu_a;
    assign o_alu_b      = w_alu_b;
    assign o_alu_op     = w_alu_op;
    assign o_result     = r_result;
    assign o_remainder  = r_remainder;
    assign o_iter_count = r_iter_count;

endmodule
